online_addsub_serial: RTL
=========================

Name: online_addsub_serial

Overview:
- Radix-2 signed-digit online adder/subtractor for N-digit, MSD-first digit streams. Successor to the fixed 2-bit online subtractor.
- Adds a run-time add/sub mode, a parametrised operand length, and exact online-delay-2 digit generation.
- Provides full valid/ready flow control with backpressure and a last-digit marker.
- Sits between online operand producers and downstream online multiply/divide stages of the Newton iteration datapath.

Parameters:
- N_DIGITS, 8, fractional digits per operand (>=2). Output is N_DIGITS+1 digits (z_0..z_N).
- CNT_W, 5, digit-counter width; must satisfy 2^CNT_W > N_DIGITS+2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- x  in  2  operand digit {p,n}, value p-n; 2'b11 accepted as 0
- y  in  2  operand digit, same encoding
- sub  in  1  1 = x-y, 0 = x+y; sampled only on the first accepted digit
- in_vld  in  1  x/y/sub valid
- in_rdy  out  1  block accepts a digit this cycle
- res  out  2  result digit: +1 = 2'b10, -1 = 2'b01, 0 = 2'b00
- out_vld  out  1  res valid
- out_rdy  in  1  downstream accepts res
- out_last  out  1  res is z_N
- busy  out  1  an operation is in progress (state != IDLE)

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, counter=0, history s_prev2=s_prev1=0, latched mode=0.
  - res=0, out_vld=0, out_last=0, busy=0.
  - Any partial stream is discarded; no residual output after release.
- Digit sum: s_j = x_j + y'_j in [-2,2].
  - y'_j = y_j when mode=add.
  - y'_j = ~y_j (bitwise invert, negates the digit) when mode=sub.
- Decomposition s_j = 2t_j + w_j, with lookahead on s_{j+1}:
  - s=2: t=1, w=0.
  - s=-2: t=-1, w=0.
  - s=0: t=0, w=0.
  - s=1: if s_{j+1} >= 1 then t=1, w=-1; else t=0, w=1.
  - s=-1: if s_{j+1} <= -1 then t=-1, w=1; else t=0, w=-1.
- Output digit z_j = w_j + t_{j+1}, always in {-1,0,1}.
  - Boundary values: s_0 = 0 (so w_0 = 0), and s_{N+1} = s_{N+2} = 0.
  - Sum value = z_0 + sum over j of z_j*2^-j; must be exact.
- States:
  - IDLE: waiting for the first digit.
  - RUN: digits 1..N.
  - FLUSH: two internal beats with s = 0.
- Beat k (digit k accepted, or flush beat k = N+1, N+2) computes z_{k-2} from s_{k-2}, s_{k-1}, s_k.
  - Beat 1 produces no output.
  - Beats 2..N+2 each load one digit into the output register, so online delay = 2.
  - Output register loads on the clock edge ending the beat, so res is valid the cycle after.
- in_rdy (combinational) = (state==IDLE || state==RUN) && (!out_vld || out_rdy).
  - in_rdy = 0 throughout FLUSH.
  - In IDLE, beat 1 needs no output slot, but the same rule applies for simplicity.
- A FLUSH beat fires when !out_vld || out_rdy.
- Transitions:
  - IDLE to RUN on the accepted first digit; mode is latched at that point.
  - RUN to FLUSH after digit N is accepted.
  - FLUSH to IDLE after beat N+2 loads z_N, with out_last=1.
- out_vld/res/out_last hold stable while out_vld && !out_rdy.
  - out_vld drops when out_rdy is seen and no new digit loads in the same cycle.
- Throughput: one digit per cycle with out_rdy held high. The next operation may begin in the first IDLE cycle.
- Holding sub at any value after digit 1 has no effect on the current operation.

Test Plan:
- N=4, add, x=(1,0,0,0), y=(1,0,0,0) -> res sequence 1,0,0,0,0 (value 1.0), out_last on 5th, first out_vld 2 cycles after digit 1.
- N=4, add, x=(1,1,1,1), y=(0,0,0,1) -> 1,0,0,0,0; sub with the same x,y -> digits whose value equals 14/16, all in {-1,0,1}.
- N=4, sub, x=(0,0,0,0), y=(1,0,0,0) -> 0,-1,0,0,0 (value -0.5); sub toggled after digit 1 -> identical output.
- Backpressure: random out_rdy stalls and in_vld gaps over 1000 random operands, N=8, both modes -> output value equals exact x±y, digit order preserved, res stable during stall, in_rdy=0 during FLUSH.
- Reset asserted mid-RUN (after digit 3) -> out_vld=0 and busy=0 immediately; fresh operation after release produces correct result with no stale digits.
- Back-to-back operations with out_rdy=1 -> second operation's digit 1 accepted the cycle after first's out_last load; no digit lost or duplicated.

Source files
------------

// File: rtl/online_addsub_serial.sv
// -----------------------------------------------------------------------------
// online_addsub_serial
//
// Radix-2 signed-digit online adder/subtractor. Two N_DIGITS-long fractional
// operands arrive MSD first, one digit pair per beat. The block emits
// N_DIGITS+1 result digits z_0..z_N, also MSD first, with an online delay of
// two beats. The result value is z_0 + sum(z_j * 2^-j), and it is exact.
//
// Each digit sum s_j = x_j +/- y_j lies in [-2,2]. It is split as
// s_j = 2*t_j + w_j, looking one digit ahead so that z_j = w_j + t_{j+1}
// always stays within {-1,0,1}.
//
// Digit encoding is {p,n} with value p-n. 2'b11 is accepted as 0 on input
// and is never produced on output.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   x, y         operand digits
//   sub          1 = x-y, 0 = x+y; taken from the first digit of an operation
//   in_vld       x/y/sub valid
//   in_rdy       a digit pair is accepted this cycle when in_vld is high
//   res          result digit (+1 = 2'b10, -1 = 2'b01, 0 = 2'b00)
//   out_vld      res valid
//   out_rdy      downstream accepts res
//   out_last     res is the final digit z_N
//   busy         an operation is in progress
// -----------------------------------------------------------------------------
module online_addsub_serial #(
    parameter int N_DIGITS = 8,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] x,
    input  logic [1:0] y,
    input  logic       sub,
    input  logic       in_vld,
    output logic       in_rdy,
    output logic [1:0] res,
    output logic       out_vld,
    input  logic       out_rdy,
    output logic       out_last,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic signed [2:0] P2   = 3'sd2;
    localparam logic signed [2:0] P1   = 3'sd1;
    localparam logic signed [2:0] ZERO = 3'sd0;
    localparam logic signed [2:0] M1   = -3'sd1;
    localparam logic signed [2:0] M2   = -3'sd2;

    localparam logic [CNT_W-1:0] CNT_PRE_LAST_DIGIT = CNT_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST_FLUSH = CNT_W'(N_DIGITS + 1);

    // Signed value of a {p,n} digit; 2'b11 decodes to 0.
    function automatic logic signed [2:0] digit_val(input logic [1:0] d);
        logic signed [2:0] v;
        case (d)
            2'b10:   v = P1;
            2'b01:   v = M1;
            default: v = ZERO;
        endcase
        return v;
    endfunction

    // Transfer digit t_j of s_j, using s_{j+1} as lookahead. A +/-1 sum moves
    // to the next-higher position only when the next digit has the same sign.
    // Otherwise the following w + t could reach +/-2.
    function automatic logic signed [2:0] transfer(input logic signed [2:0] s,
                                                   input logic signed [2:0] s_nxt);
        logic signed [2:0] t;
        t = ZERO;
        if (s == P2)
            t = P1;
        else if (s == M2)
            t = M1;
        else if (s == P1)
            t = (s_nxt >= P1) ? P1 : ZERO;
        else if (s == M1)
            t = (s_nxt <= M1) ? M1 : ZERO;
        return t;
    endfunction

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic signed [2:0] s_prev2;     // s_{k-2} during beat k
    logic signed [2:0] s_prev1;     // s_{k-1} during beat k
    logic              mode;        // latched sub for the running operation

    logic              use_sub;
    logic [1:0]        y_eff;
    logic signed [2:0] s_cur;
    logic signed [2:0] t_a, w_a, t_b, z;
    logic [1:0]        z_enc;
    logic              slot_free;
    logic              beat;
    logic              emit;
    logic              last_beat;

    // ------------------------------------------------------------------
    // Datapath: beat k produces z_{k-2} = w_{k-2} + t_{k-1}
    // ------------------------------------------------------------------
    always_comb begin
        // The first digit carries its own mode. The latch only takes it
        // at the end of that beat.
        use_sub = (state == IDLE) ? sub : mode;
        // Bitwise inversion of {p,n} swaps p and n, which negates the digit.
        y_eff   = use_sub ? ~y : y;
        s_cur   = (state == FLUSH) ? ZERO : (digit_val(x) + digit_val(y_eff));

        t_a     = transfer(s_prev2, s_prev1);
        w_a     = s_prev2 - (t_a <<< 1);
        t_b     = transfer(s_prev1, s_cur);
        z       = w_a + t_b;

        if (z == P1)
            z_enc = 2'b10;
        else if (z == M1)
            z_enc = 2'b01;
        else
            z_enc = 2'b00;
    end

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    assign slot_free = !out_vld || out_rdy;
    assign in_rdy    = ((state == IDLE) || (state == RUN)) && slot_free;
    assign beat      = (state == FLUSH) ? slot_free : (in_vld && in_rdy);
    // Beat 1 (from IDLE) only primes the history and produces no digit.
    assign emit      = beat && (state != IDLE);
    assign last_beat = (state == FLUSH) && (cnt == CNT_PRE_LAST_FLUSH);
    assign busy      = (state != IDLE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first. A path
        // that skipped an assignment would infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (beat) begin
                    state_nxt = RUN;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            RUN: begin
                if (beat) begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == CNT_PRE_LAST_DIGIT)
                        state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (beat) begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (last_beat) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, history and output register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples the values from before the edge, whatever the
    // statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            s_prev2  <= ZERO;
            s_prev1  <= ZERO;
            mode     <= 1'b0;
            res      <= 2'b00;
            out_vld  <= 1'b0;
            out_last <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;

            if (beat) begin
                // Beat 1 starts from s_0 = 0 no matter what the previous
                // operation left behind.
                s_prev2 <= (state == IDLE) ? ZERO : s_prev1;
                s_prev1 <= s_cur;
            end

            if ((state == IDLE) && beat)
                mode <= sub;

            if (emit) begin
                res      <= z_enc;
                out_vld  <= 1'b1;
                out_last <= last_beat;
            end else if (out_rdy) begin
                out_vld  <= 1'b0;
                out_last <= 1'b0;
            end
        end
    end

endmodule
